hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage MIPS core. Resolves RAW hazards by forwarding, and inserts load-use and branch-compare stalls. It also sequences the EX/MEM register and the stages behind it through variable-latency data-memory accesses using a req/ready handshake with a timeout. A cycle counter records total stall cycles for performance analysis.

---
 rtl/hazard_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard and stall controller for the 5-stage MIPS pipeline.
//   - Resolves RAW hazards by forwarding into the Decode comparator and the ALU.
//   - Inserts load-use and branch-compare bubbles.
//   - Holds EX/MEM and the stages behind it through variable-latency
//     data-memory accesses (req/ready handshake with a wait timeout).
//   - Counts stall cycles (saturating) for performance analysis.
//
// Ports
//   CLK, reset               clock, synchronous active-low reset
//   RsD/RtD, RsE/RtE         source registers in Decode / Execute
//   WriteReg{E,M,W}          destination registers per stage
//   RegWrite{E,M,W}          register-write enables per stage
//   MemtoReg{E,M}, MemWriteM load in E/M, store in M
//   BranchD                  branch compare in Decode
//   MemReadyM                data memory completes the access this cycle
//   MemReqM                  data-memory request
//   Stall{F,D,E,M}           hold PC, IF/ID, ID/EX, EX/MEM
//   Flush{E,W}               bubble into ID/EX, MEM/WB
//   Forward{A,B}D            Decode comparator operand select
//   Forward{A,B}E            ALU operand select (00 regfile, 01 WB, 10 ALUResultM)
//   MemErr                   sticky memory-timeout flag
//   StallCycles              saturating stall-cycle count
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             MemWriteM,
  input  logic             BranchD,
  input  logic             MemReadyM,
  output logic             MemReqM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushE,
  output logic             FlushW,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCycles
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;
  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  logic [0:0]       state_reg, state_next;
  logic [7:0]       wcnt_reg, wcnt_next;
  logic             mem_err_reg, mem_err_next;
  logic [CNT_W-1:0] cnt_reg;

  logic             memacc, memstall, lwstall, brstall;
  logic [4:0]       src_e [2];
  logic [4:0]       src_d [2];
  logic [1:0]       fwd_e [2];
  logic             fwd_d [2];
  logic             d_hit_e [2];
  logic             d_hit_m [2];

  // Register 0 is hard-wired, so it never creates a dependency.
  function automatic logic reg_hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  assign src_e[0] = RsE;
  assign src_e[1] = RtE;
  assign src_d[0] = RsD;
  assign src_d[1] = RtD;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      always_comb begin
        fwd_e[gi] = 2'b00;
        if (RegWriteM && reg_hit(WriteRegM, src_e[gi]))
          fwd_e[gi] = 2'b10;
        else if (RegWriteW && reg_hit(WriteRegW, src_e[gi]))
          fwd_e[gi] = 2'b01;
      end
      assign fwd_d[gi]   = RegWriteM && reg_hit(WriteRegM, src_d[gi]);
      assign d_hit_e[gi] = RegWriteE && reg_hit(WriteRegE, src_d[gi]);
      assign d_hit_m[gi] = MemtoRegM && reg_hit(WriteRegM, src_d[gi]);
    end
  endgenerate

  assign memacc  = MemtoRegM || MemWriteM;
  assign lwstall = MemtoRegE && (reg_hit(RtE, RsD) || reg_hit(RtE, RtD));
  assign brstall = BranchD && (d_hit_e[0] || d_hit_e[1] || d_hit_m[0] || d_hit_m[1]);

  // Memory wait sequencing. The timeout cycle drops the stall so the
  // pipeline moves on, abandoning the access and latching the error.
  always_comb begin
    state_next   = state_reg;
    wcnt_next    = wcnt_reg;
    mem_err_next = mem_err_reg;
    memstall     = 1'b0;
    case (state_reg)
      ST_RUN: begin
        if (memacc && !MemReadyM) begin
          memstall   = 1'b1;
          state_next = ST_WAIT;
          wcnt_next  = 8'd1;
        end
      end
      ST_WAIT: begin
        if (MemReadyM) begin
          state_next = ST_RUN;
          wcnt_next  = 8'd0;
        end else if (wcnt_reg < TIMEOUT) begin
          memstall  = 1'b1;
          wcnt_next = wcnt_reg + 8'd1;
        end else begin
          mem_err_next = 1'b1;
          state_next   = ST_RUN;
          wcnt_next    = 8'd0;
        end
      end
      default: begin
        state_next = ST_RUN;
        wcnt_next  = 8'd0;
      end
    endcase
  end

  // Memory stall freezes everything up to EX/MEM; a load-use or branch
  // stall only holds the front end and bubbles ID/EX.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    MemReqM   = 1'b0;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (reset) begin
      MemReqM   = memacc;
      ForwardAD = fwd_d[0];
      ForwardBD = fwd_d[1];
      ForwardAE = fwd_e[0];
      ForwardBE = fwd_e[1];
      if (memstall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (lwstall || brstall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_reg   <= ST_RUN;
      wcnt_reg    <= 8'd0;
      mem_err_reg <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      wcnt_reg    <= wcnt_next;
      mem_err_reg <= mem_err_next;
      if ((StallF || StallE || StallM) && (cnt_reg != '1))
        cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign MemErr      = mem_err_reg;
  assign StallCycles = cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int TO    = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          reset;
  logic [4:0]    RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic          RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemWriteM;
  logic          BranchD, MemReadyM;
  logic          MemReqM, StallF, StallD, StallE, StallM, FlushE, FlushW;
  logic          ForwardAD, ForwardBD;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          MemErr;
  logic [CW-1:0] StallCycles;

  int tests = 0;
  int fails = 0;

  // Reference state: cycles already waited in the current access (0 = none),
  // sticky error, stall count.
  int m_wait;
  bit m_err;
  int m_cnt;

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .CLK(CLK), .reset(reset),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .BranchD(BranchD), .MemReadyM(MemReadyM), .MemReqM(MemReqM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemErr(MemErr), .StallCycles(StallCycles)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit rz(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  task automatic idle();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0; MemWriteM = 0;
    BranchD = 0; MemReadyM = 1;
  endtask

  // One clock cycle: check every output against the reference, then advance
  // the reference across the rising edge.
  task automatic cyc();
    bit macc, ms, lw, br, sf, sd, se, sm, fe, fw, req, fad, fbd;
    logic [1:0] fae, fbe;
    #1;
    macc = MemtoRegM || MemWriteM;
    {ms, lw, br, sf, sd, se, sm, fe, fw, req, fad, fbd} = '0;
    fae = 0; fbe = 0;
    if (reset) begin
      fae = (RegWriteM && rz(WriteRegM, RsE)) ? 2'd2 : (RegWriteW && rz(WriteRegW, RsE)) ? 2'd1 : 2'd0;
      fbe = (RegWriteM && rz(WriteRegM, RtE)) ? 2'd2 : (RegWriteW && rz(WriteRegW, RtE)) ? 2'd1 : 2'd0;
      fad = RegWriteM && rz(WriteRegM, RsD);
      fbd = RegWriteM && rz(WriteRegM, RtD);
      lw  = MemtoRegE && (rz(RtE, RsD) || rz(RtE, RtD));
      br  = BranchD && ((RegWriteE && (rz(WriteRegE, RsD) || rz(WriteRegE, RtD))) ||
                        (MemtoRegM && (rz(WriteRegM, RsD) || rz(WriteRegM, RtD))));
      ms  = (m_wait == 0) ? (macc && !MemReadyM) : (!MemReadyM && m_wait < TO);
      req = macc;
      if (ms) begin
        sf = 1; sd = 1; se = 1; sm = 1; fw = 1;
      end else if (lw || br) begin
        sf = 1; sd = 1; fe = 1;
      end
    end
    chk("ForwardAE", 32'(ForwardAE), 32'(fae));
    chk("ForwardBE", 32'(ForwardBE), 32'(fbe));
    chk("ForwardAD", 32'(ForwardAD), 32'(fad));
    chk("ForwardBD", 32'(ForwardBD), 32'(fbd));
    chk("stalls", 32'({StallF, StallD, StallE, StallM}), 32'({sf, sd, se, sm}));
    chk("flushes", 32'({FlushE, FlushW}), 32'({fe, fw}));
    chk("MemReqM", 32'(MemReqM), 32'(req));
    chk("MemErr", 32'(MemErr), 32'(m_err));
    chk("StallCycles", 32'(StallCycles), 32'(m_cnt));
    @(posedge CLK);
    if (!reset) begin
      m_wait = 0; m_err = 0; m_cnt = 0;
    end else begin
      if ((sf || se || sm) && m_cnt < CMAX) m_cnt++;
      if (m_wait == 0) begin
        if (macc && !MemReadyM) m_wait = 1;
      end else if (MemReadyM) begin
        m_wait = 0;
      end else if (m_wait < TO) begin
        m_wait++;
      end else begin
        m_err  = 1;
        m_wait = 0;
      end
    end
    #1;
  endtask

  initial begin
    m_wait = 0; m_err = 0; m_cnt = 0;
    idle();
    reset = 0;
    // Reset: outputs gated even with a pending access.
    MemtoRegM = 1; MemReadyM = 0; RegWriteM = 1; WriteRegM = 3; RsE = 3;
    cyc(); cyc();
    #1;
    chk("rst_req", 32'(MemReqM), 0);
    chk("rst_stallF", 32'(StallF), 0);
    chk("rst_fwd", 32'(ForwardAE), 0);
    chk("rst_cnt", 32'(StallCycles), 0);
    chk("rst_err", 32'(MemErr), 0);
    idle(); reset = 1;
    cyc();

    // Forwarding priority and register 0.
    RegWriteM = 1; WriteRegM = 3; RsE = 3; RegWriteW = 1; WriteRegW = 3;
    #1 chk("fwd_m", 32'(ForwardAE), 2); cyc();
    RegWriteM = 0;
    #1 chk("fwd_w", 32'(ForwardAE), 1); cyc();
    WriteRegW = 0; RsE = 0;
    #1 chk("fwd_r0", 32'(ForwardAE), 0); cyc();

    // Load-use: one bubble, then forward from WB.
    idle();
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 2; RtE = 2; RsD = 2; RtD = 5;
    #1 chk("lu_stall", 32'({StallF, StallD, FlushE, StallE}), 32'(4'b1110)); cyc();
    MemtoRegE = 0; RegWriteE = 0; WriteRegE = 0; RtE = 0;
    MemtoRegM = 1; RegWriteM = 1; WriteRegM = 2; MemReadyM = 1;
    #1 chk("lu_once", 32'(StallF), 0); cyc();
    MemtoRegM = 0; RegWriteM = 0; WriteRegM = 0; RegWriteW = 1; WriteRegW = 2;
    RsE = 2; RtE = 5; RsD = 0; RtD = 0;
    #1 chk("lu_fwd", 32'(ForwardAE), 1); chk("lu_nostall", 32'(StallF), 0); cyc();

    // Three wait cycles then ready.
    idle(); reset = 0; cyc(); reset = 1;
    MemtoRegM = 1; RegWriteM = 1; WriteRegM = 7; MemReadyM = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("w3_stall", 32'({StallF, StallE, StallM, FlushW, FlushE}), 32'(5'b11110)); cyc();
    end
    MemReadyM = 1;
    #1 chk("w3_release", 32'(StallM), 0); cyc();
    idle(); MemReadyM = 0;
    #1 chk("w3_cnt", 32'(StallCycles), 3); chk("w3_err", 32'(MemErr), 0);
    chk("w3_run", 32'(StallM), 0); cyc();

    // Timeout: four stalled cycles, released on the fifth with the request up.
    idle(); MemWriteM = 1; MemReadyM = 0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("to_stall", 32'(StallM), 1); cyc();
    end
    #1 chk("to_release", 32'(StallM), 0); chk("to_req", 32'(MemReqM), 1); cyc();
    idle();
    #1 chk("to_err", 32'(MemErr), 1); chk("to_cnt", 32'(StallCycles), 7);
    cyc(); cyc(); cyc();
    chk("to_err_held", 32'(MemErr), 1);

    // Memory stall overlapping a load-use stall.
    idle(); MemtoRegM = 1; MemReadyM = 0; MemtoRegE = 1; RtE = 2; RsD = 2;
    for (int i = 0; i < 2; i++) begin
      #1 chk("ov_flushE", 32'({FlushE, StallE}), 32'(2'b01)); cyc();
    end
    MemReadyM = 1;
    #1 chk("ov_bubble", 32'({FlushE, StallF, StallM}), 32'(3'b110)); cyc();
    MemtoRegE = 0; RtE = 0;
    #1 chk("ov_once", 32'(FlushE), 0); cyc();

    // Reset in the middle of a wait.
    idle(); MemtoRegM = 1; MemReadyM = 0;
    cyc(); cyc();
    reset = 0;
    #1 chk("rw_gate", 32'({StallF, MemReqM}), 0); cyc();
    reset = 1; idle(); MemReadyM = 0;
    #1 chk("rw_cnt", 32'(StallCycles), 0); chk("rw_err", 32'(MemErr), 0);
    chk("rw_run", 32'(StallM), 0); cyc();

    // Stall counter saturation via repeated timeouts.
    MemtoRegM = 1; MemReadyM = 0;
    repeat (20) cyc();
    idle();
    #1 chk("sat_cnt", 32'(StallCycles), CMAX); cyc();

    // Randomized traffic against the reference.
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 59) != 0);
      RsD       = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
      RsE       = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3)); WriteRegM = 5'($urandom_range(0, 3));
      WriteRegW = 5'($urandom_range(0, 3));
      RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      MemtoRegE = ($urandom_range(0, 3) == 0);
      MemtoRegM = ($urandom_range(0, 2) == 0);
      MemWriteM = ($urandom_range(0, 4) == 0);
      BranchD   = ($urandom_range(0, 2) == 0);
      MemReadyM = ($urandom_range(0, 2) != 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
